// File: rtl/mdu_seq_ctrl_if.sv
// HI/LO multiply/divide sequencer bus.
// EX-stage control in, stall/result out.
interface mdu_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             is_div_i;
  logic             is_mult_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cancel_i;
  logic             hold_i;
  logic             stall_o;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport slave (
    input  start_i, is_div_i, is_mult_i,
    input  signed_i, a_i, b_i,
    input  cancel_i, hold_i,
    output stall_o, busy_o, valid_o,
    output hi_o, lo_o
  );

  modport master (
    output start_i, is_div_i, is_mult_i,
    output signed_i, a_i, b_i,
    output cancel_i, hold_i,
    input  stall_o, busy_o, valid_o,
    input  hi_o, lo_o
  );
endinterface

// File: rtl/mdu_seq_ctrl.sv
// HI/LO multiply/divide sequencer for EX.
// Multi-cycle multiply, restoring divide.
module mdu_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  mdu_seq_ctrl_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int MX = (WIDTH > MUL_LAT)
                    ? WIDTH : MUL_LAT;
  localparam int CW = (MX > 2) ? $clog2(MX) : 1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] rem;
  logic             sg;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             div_go;
  logic             mul_go;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]   shf;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quot_n;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // Operand prep, product and one divide step.
  always_comb begin
    div_go = bus.start_i & bus.is_div_i;
    mul_go = bus.start_i & ~bus.is_div_i
           & bus.is_mult_i;
    a_neg  = bus.signed_i & bus.a_i[WIDTH-1];
    b_neg  = bus.signed_i & bus.b_i[WIDTH-1];
    a_abs  = a_neg ? -bus.a_i : bus.a_i;
    b_abs  = b_neg ? -bus.b_i : bus.b_i;
    ext_a  = {{WIDTH{sg & op_a[WIDTH-1]}}, op_a};
    ext_b  = {{WIDTH{sg & op_b[WIDTH-1]}}, op_b};
    prod   = ext_a * ext_b;
    shf    = {rem, op_a[WIDTH-1]};
    diff   = shf - {1'b0, op_b};
    ge     = ~diff[WIDTH];
    rem_n  = ge ? diff[WIDTH-1:0]
                : shf[WIDTH-1:0];
    quot_n = {op_a[WIDTH-2:0], ge};
    q_fin  = q_neg ? -quot_n : quot_n;
    r_fin  = r_neg ? -rem_n : rem_n;
  end

  // Sequencer state, counter, datapath and result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      rem   <= '0;
      sg    <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (bus.cancel_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_go) begin
            if (bus.b_i == '0) begin
              state <= DONE;
              hi_q  <= bus.a_i;
              lo_q  <= '1;
            end else begin
              state <= DIV;
              cnt   <= CW'(WIDTH-1);
              op_a  <= a_abs;
              op_b  <= b_abs;
              rem   <= '0;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
            end
          end else if (mul_go) begin
            state <= MUL;
            cnt   <= CW'(MUL_LAT-1);
            op_a  <= bus.a_i;
            op_b  <= bus.b_i;
            sg    <= bus.signed_i;
          end
        end
        MUL: begin
          if (cnt == '0) begin
            state <= DONE;
            hi_q  <= prod[2*WIDTH-1:WIDTH];
            lo_q  <= prod[WIDTH-1:0];
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DIV: begin
          op_a <= quot_n;
          rem  <= rem_n;
          if (cnt == '0) begin
            state <= DONE;
            hi_q  <= r_fin;
            lo_q  <= q_fin;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          if (!bus.hold_i) state <= IDLE;
        end
      endcase
    end
  end

  // Stall covers the start cycle and every busy cycle.
  always_comb begin
    bus.busy_o  = (state == MUL) | (state == DIV);
    bus.valid_o = (state == DONE);
    bus.stall_o = rst & ~bus.cancel_i
                & (bus.busy_o
                   | ((state == IDLE)
                      & (div_go | mul_go)));
    bus.hi_o    = hi_q;
    bus.lo_o    = lo_q;
  end
endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Bench for mdu_seq_ctrl: reference model,
// per-cycle compare, directed and random ops.
module tb_mdu_seq_ctrl;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mdu_seq_ctrl_if #(.WIDTH(W)) ifc ();

  mdu_seq_ctrl #(
    .WIDTH  (W),
    .MUL_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, need %h",
               nm, act, exp);
    end
  endtask

  // Architectural result: {hi, lo}.
  function automatic logic [63:0] ref_res(
    input bit dv, input bit sgn,
    input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, up;
    if (dv) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa * sb;
      return q;
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    up = ua * ub;
    return up;
  endfunction

  // Model: cycles left busy, done flag, result.
  int          m_left;
  bit          m_done;
  logic [63:0] m_res;
  logic [63:0] p_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      p_res  <= '0;
    end else if (ifc.cancel_i) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (!ifc.hold_i) m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= p_res;
      end
    end else if (ifc.start_i) begin
      if (ifc.is_div_i && ifc.b_i == 32'd0) begin
        m_done <= 1'b1;
        m_res  <= ref_res(1'b1, ifc.signed_i,
                          ifc.a_i, ifc.b_i);
      end else begin
        m_left <= ifc.is_div_i ? W : LAT;
        p_res  <= ref_res(ifc.is_div_i,
                          ifc.signed_i,
                          ifc.a_i, ifc.b_i);
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    chk("stall", 32'(ifc.stall_o),
        32'(rst && !ifc.cancel_i
            && (m_left > 0
                || (!m_done && ifc.start_i))));
    chk("busy", 32'(ifc.busy_o), 32'(m_left > 0));
    chk("valid", 32'(ifc.valid_o), 32'(m_done));
    chk("hi", ifc.hi_o, m_res[63:32]);
    chk("lo", ifc.lo_o, m_res[31:0]);
  end

  task automatic idle_in();
    ifc.start_i   = 1'b0;
    ifc.is_div_i  = 1'b0;
    ifc.is_mult_i = 1'b0;
    ifc.signed_i  = 1'b0;
    ifc.a_i       = '0;
    ifc.b_i       = '0;
    ifc.cancel_i  = 1'b0;
    ifc.hold_i    = 1'b0;
  endtask

  task automatic run_op(
    input bit dv, input bit sgn,
    input logic [31:0] a, input logic [31:0] b,
    input int hold_n, input int exp_st,
    output logic [31:0] hi,
    output logic [31:0] lo);
    int st;
    bit got;
    @(posedge clk); #1;
    ifc.start_i   = 1'b1;
    ifc.is_div_i  = dv;
    ifc.is_mult_i = !dv;
    ifc.signed_i  = sgn;
    ifc.a_i       = a;
    ifc.b_i       = b;
    ifc.hold_i    = (hold_n > 0);
    st  = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (ifc.valid_o) got = 1'b1;
      else if (ifc.stall_o) st++;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("stall_cycles", st, exp_st);
    hi = ifc.hi_o;
    lo = ifc.lo_o;
    for (int k = 0; k < hold_n; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(ifc.valid_o), 32'd1);
      chk("hold_busy", 32'(ifc.busy_o), 32'd0);
      chk("hold_hi", ifc.hi_o, hi);
      chk("hold_lo", ifc.lo_o, lo);
    end
    @(posedge clk); #1;
    if (hold_n > 0) begin
      ifc.hold_i = 1'b0;
      @(posedge clk); #1;
    end
    ifc.start_i = 1'b0;
    @(negedge clk);
    chk("after_valid", 32'(ifc.valid_o), 32'd0);
    chk("after_busy", 32'(ifc.busy_o), 32'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  logic [31:0] hi, lo;

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_in();
    rst = 1'b1;
    #2 rst = 1'b0;
    ifc.start_i  = 1'b1;
    ifc.is_div_i = 1'b1;
    ifc.b_i      = 32'd3;
    @(negedge clk);
    chk("rst_stall", 32'(ifc.stall_o), 32'd0);
    chk("rst_valid", 32'(ifc.valid_o), 32'd0);
    chk("rst_lo", ifc.lo_o, 32'd0);
    @(posedge clk); #1;
    idle_in();
    rst = 1'b1;

    run_op(1, 0, 32'd100, 32'd7, 0, 33, hi, lo);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    run_op(1, 1, 32'hFFFF_FFF9, 32'd2, 0, 33,
           hi, lo);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF,
           0, 33, hi, lo);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    run_op(0, 1, 32'hFFFF_FFFD, 32'd5, 0, 3,
           hi, lo);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    run_op(0, 0, 32'hFFFF_FFFF, 32'd2, 0, 3,
           hi, lo);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(1, 0, 32'h1234, 32'd0, 0, 1, hi, lo);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_lo", lo, 32'hFFFF_FFFF);

    // cancel in the 10th divide cycle
    @(posedge clk); #1;
    ifc.start_i  = 1'b1;
    ifc.is_div_i = 1'b1;
    ifc.a_i      = 32'd1000;
    ifc.b_i      = 32'd3;
    repeat (10) @(posedge clk);
    #1 ifc.cancel_i = 1'b1;
    @(negedge clk);
    chk("cancel_stall", 32'(ifc.stall_o), 32'd0);
    chk("cancel_busy", 32'(ifc.busy_o), 32'd1);
    @(posedge clk); #1;
    idle_in();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cancel_novalid", 32'(ifc.valid_o), 32'd0);
      chk("cancel_idle", 32'(ifc.busy_o), 32'd0);
    end
    run_op(0, 0, 32'd6, 32'd7, 0, 3, hi, lo);
    chk("post_cancel_lo", lo, 32'd42);
    chk("post_cancel_hi", hi, 32'd0);

    // hold in DONE with start still high
    run_op(0, 1, 32'd9, 32'hFFFF_FFFE, 3, 3,
           hi, lo);
    chk("hold_res_lo", lo, 32'hFFFF_FFEE);
    chk("hold_res_hi", hi, 32'hFFFF_FFFF);

    // async reset mid-divide
    @(posedge clk); #1;
    ifc.start_i  = 1'b1;
    ifc.is_div_i = 1'b1;
    ifc.a_i      = 32'd77;
    ifc.b_i      = 32'd5;
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(ifc.busy_o), 32'd0);
    chk("arst_stall", 32'(ifc.stall_o), 32'd0);
    chk("arst_valid", 32'(ifc.valid_o), 32'd0);
    chk("arst_hi", ifc.hi_o, 32'd0);
    chk("arst_lo", ifc.lo_o, 32'd0);
    idle_in();
    @(posedge clk); #1;
    rst = 1'b1;

    // random per-cycle stimulus
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      ifc.start_i   = ($urandom_range(0, 9) < 4);
      ifc.is_div_i  = $urandom_range(0, 1) == 1;
      ifc.is_mult_i = !ifc.is_div_i
                    || ($urandom_range(0, 3) == 0);
      ifc.signed_i  = $urandom_range(0, 1) == 1;
      ifc.a_i       = rnd_op();
      ifc.b_i       = rnd_op();
      ifc.cancel_i  = ($urandom_range(0, 99) < 2);
      ifc.hold_i    = $urandom_range(0, 1) == 1;
    end
    @(posedge clk); #1;
    idle_in();
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
